// File: rtl/pcileech_com_tx_arbiter.sv
// ============================================================================
// Module  : pcileech_com_tx_arbiter
// Brief   : Round-robin, packet-locked arbiter of three FIFO sources onto the
//           tagged 32-bit COM TX word path, with a per-grant stall watchdog.
//           Define PCILEECH_COM_ARB_STATS_EN to add per-channel word/abort stats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pcileech_com_tx_arbiter #(
  parameter int NUM_CH        = 3,
  parameter int MAX_BURST     = 64,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*32-1:0] req_data,
  input  logic [NUM_CH-1:0]    req_last,
  output logic [NUM_CH-1:0]    req_ready,
  output logic                 tx_valid,
  output logic [31:0]          tx_data,
  output logic [1:0]           tx_tag,
  output logic                 tx_last,
  input  logic                 tx_ready,
  output logic                 err_stall,
  input  logic                 err_clr,
  output logic [1:0]           grant_ch
`ifdef PCILEECH_COM_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0] stat_words,
  output logic [15:0]          stat_aborts
`endif
);

  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_GRANT      = 2'd1;
  localparam logic [1:0]  c_ABORT      = 2'd2;
  localparam logic [7:0]  c_BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [15:0] c_STALL_LAST = 16'(STALL_TIMEOUT - 1);
  localparam logic [1:0]  c_LAST_CH    = 2'(NUM_CH - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_rr;
  logic [7:0]  r_burst_cnt;
  logic [15:0] r_stall_cnt;

  logic        w_out_free;
  logic        w_valid_g;
  logic        w_accept;
  logic        w_word_last;
  logic        w_burst_end;
  logic        w_abort_emit;
  logic [31:0] w_word;
  logic [1:0]  w_rr_next;
  logic [1:0]  w_pick;
  logic [2:0]  w_idx;

  // Single-stage output skid: the source may push whenever the register drains.
  assign w_out_free   = ~tx_valid | tx_ready;
  assign w_valid_g    = req_valid[grant_ch];
  assign w_accept     = (r_state == c_GRANT) & w_valid_g & w_out_free;
  assign w_word       = req_data[{grant_ch, 5'd0} +: 32];
  assign w_word_last  = req_last[grant_ch];
  assign w_burst_end  = (r_burst_cnt == c_BURST_LAST);
  assign w_abort_emit = (r_state == c_ABORT) & w_out_free;
  assign w_rr_next    = (grant_ch == c_LAST_CH) ? 2'd0 : grant_ch + 2'd1;

  always_comb begin
    req_ready = '0;
    if (r_state == c_GRANT) begin
      req_ready[grant_ch] = w_out_free;
    end
  end

  // Scan from the rr pointer upward with wrap; the nearest requester wins.
  always_comb begin
    w_pick = r_rr;
    w_idx  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr} + 3'(k);
      if (w_idx >= 3'(NUM_CH)) begin
        w_idx = w_idx - 3'(NUM_CH);
      end
      if (req_valid[w_idx]) begin
        w_pick = w_idx[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_rr        <= '0;
      grant_ch    <= '0;
      r_burst_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (|req_valid) begin
            grant_ch    <= w_pick;
            r_burst_cnt <= '0;
            r_stall_cnt <= '0;
            r_state     <= c_GRANT;
          end
        end
        c_GRANT: begin
          if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
            r_stall_cnt <= '0;
            if (w_word_last | w_burst_end) begin
              r_rr    <= w_rr_next;
              r_state <= c_IDLE;
            end
          end else if (!w_valid_g) begin
            // Only source starvation counts; sink backpressure never does.
            if (r_stall_cnt == c_STALL_LAST) begin
              r_state <= c_ABORT;
            end else begin
              r_stall_cnt <= r_stall_cnt + 16'd1;
            end
          end
        end
        c_ABORT: begin
          if (w_out_free) begin
            r_rr    <= w_rr_next;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_tag   <= '0;
      tx_last  <= 1'b0;
    end else if (w_accept) begin
      tx_valid <= 1'b1;
      tx_data  <= w_word;
      tx_tag   <= grant_ch;
      tx_last  <= w_word_last | w_burst_end;
    end else if (w_abort_emit) begin
      tx_valid <= 1'b1;
      tx_data  <= 32'hFFFF_FFFF;
      tx_tag   <= grant_ch;
      tx_last  <= 1'b1;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  // Setting on an abort takes precedence over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stall <= 1'b0;
    end else if (w_abort_emit) begin
      err_stall <= 1'b1;
    end else if (err_clr) begin
      err_stall <= 1'b0;
    end
  end

`ifdef PCILEECH_COM_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stat_ch
    logic [31:0] r_words;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_words <= '0;
      end else if (err_clr) begin
        r_words <= '0;
      end else if (w_accept && (grant_ch == 2'(gi)) && (r_words != '1)) begin
        r_words <= r_words + 32'd1;
      end
    end
    assign stat_words[32*gi +: 32] = r_words;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_aborts <= '0;
    end else if (err_clr) begin
      stat_aborts <= '0;
    end else if (w_abort_emit && (stat_aborts != '1)) begin
      stat_aborts <= stat_aborts + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcileech_com_tx_arbiter.sv
// ============================================================================
// Module  : tb_pcileech_com_tx_arbiter
// Brief   : Scoreboard bench for the COM TX arbiter (MAX_BURST=64, STALL_TIMEOUT=16).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcileech_com_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [95:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic [1:0]  tx_tag;
  logic        tx_last;
  logic        tx_ready;
  logic        err_stall;
  logic        err_clr;
  logic [1:0]  grant_ch;
`ifdef PCILEECH_COM_ARB_STATS_EN
  logic [95:0] stat_words;
  logic [15:0] stat_aborts;
`endif

  logic        v [3];
  logic [31:0] d [3];
  logic        l [3];

  assign req_valid = {v[2], v[1], v[0]};
  assign req_last  = {l[2], l[1], l[0]};
  assign req_data  = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  pcileech_com_tx_arbiter #(
    .NUM_CH       (3),
    .MAX_BURST    (64),
    .STALL_TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_tag   (tx_tag),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .err_stall(err_stall),
    .err_clr  (err_clr),
    .grant_ch (grant_ch)
`ifdef PCILEECH_COM_ARB_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_aborts(stat_aborts)
`endif
  );

  // Expected word entries: {tag[1:0], last, data[31:0]}
  logic [34:0] exp_q[$];
  int          xfer_cyc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_off  = 1'b0;
  bit          wd_gap_chk = 1'b0;
  int          cyc = 0;
  int          last_xfer_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] ent(input int tag, input bit last, input logic [31:0] data);
    return {2'(tag), last, data};
  endfunction

  initial begin : monitor
    logic        held;
    logic [34:0] held_v;
    logic [34:0] got;
    logic [34:0] e;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || mon_off) begin
        held = 1'b0;
      end else begin
        got = {tx_tag, tx_last, tx_data};
        if (held) chk("stall_hold", 64'(got), 64'(held_v));
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h expected none", got);
          end else begin
            e = exp_q.pop_front();
            chk("tx_word", 64'(got), 64'(e));
            if (wd_gap_chk && e[31:0] == 32'hFFFF_FFFF)
              chk("wd_gap_in_range", 64'((cyc - last_xfer_cyc) >= 16 && (cyc - last_xfer_cyc) <= 19), 64'd1);
          end
          last_xfer_cyc = cyc;
          xfer_cyc_q.push_back(cyc);
        end
        held   = tx_valid && !tx_ready;
        held_v = got;
      end
    end
  end

  task automatic send_pkt(input int ch, input logic [31:0] base, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      v[ch] = 1'b1;
      d[ch] = base + 32'(i);
      l[ch] = with_last && (i == n - 1);
      @(negedge clk);
      while (!req_ready[ch] && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        chk("req_ready_timeout", 64'(t), 64'd0);
        i = n;
      end
      @(posedge clk);
      #1;
    end
    v[ch] = 1'b0;
    l[ch] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      v[c] = 1'b0;
      l[c] = 1'b0;
      d[c] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_last", 64'(tx_last), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_err_stall", 64'(err_stall), 64'd0);
    chk("rst_grant_ch", 64'(grant_ch), 64'd0);
    exp_q.delete();
    xfer_cyc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    err_clr  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      v[c] = 1'b0;
      l[c] = 1'b0;
      d[c] = '0;
    end

    // Single cfg packet of four words, sink always ready
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(1, i == 3, 32'h11 + 32'(i)));
    send_pkt(1, 32'h11, 4, 1'b1);
    wait_drain(100);
    chk("cfg_xfer_count", 64'(xfer_cyc_q.size()), 64'd4);
    if (xfer_cyc_q.size() == 4)
      chk("cfg_consecutive", 64'(xfer_cyc_q[3] - xfer_cyc_q[0]), 64'd3);

    // All three channels busy with 2-word packets: strict 0,1,2,0,1,2 rotation
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back(ent(c, 1'b0, 32'h100 * 32'(c + 1) + 32'(16 * rep)));
        exp_q.push_back(ent(c, 1'b1, 32'h100 * 32'(c + 1) + 32'(16 * rep) + 32'd1));
      end
    fork
      begin send_pkt(0, 32'h100, 2, 1'b1); send_pkt(0, 32'h110, 2, 1'b1); end
      begin send_pkt(1, 32'h200, 2, 1'b1); send_pkt(1, 32'h210, 2, 1'b1); end
      begin send_pkt(2, 32'h300, 2, 1'b1); send_pkt(2, 32'h310, 2, 1'b1); end
    join
    wait_drain(100);

    // 150-word TLP packet cut at 64 and 128; cfg/core packets slot in after the first cut
    do_reset();
    for (int i = 1; i <= 64; i++) exp_q.push_back(ent(0, i == 64, 32'h0A00_0000 + 32'(i)));
    exp_q.push_back(ent(1, 1'b0, 32'h0B00_0000));
    exp_q.push_back(ent(1, 1'b1, 32'h0B00_0001));
    exp_q.push_back(ent(2, 1'b0, 32'h0C00_0000));
    exp_q.push_back(ent(2, 1'b1, 32'h0C00_0001));
    for (int i = 65; i <= 150; i++)
      exp_q.push_back(ent(0, (i == 128) || (i == 150), 32'h0A00_0000 + 32'(i)));
    fork
      send_pkt(0, 32'h0A00_0001, 150, 1'b1);
      send_pkt(1, 32'h0B00_0000, 2, 1'b1);
      send_pkt(2, 32'h0C00_0000, 2, 1'b1);
    join
    wait_drain(200);

    // Backpressure: tx_ready toggles every cycle during an 8-word packet
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(0, i == 7, 32'h40 + 32'(i)));
    fork
      send_pkt(0, 32'h40, 8, 1'b1);
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          tx_ready = ~tx_ready;
        end
        tx_ready = 1'b1;
      end
    join
    tx_ready = 1'b1;
    wait_drain(100);

    // Sink held off for a long time: no watchdog abort may occur
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(ent(1, i == 2, 32'h50 + 32'(i)));
    fork
      send_pkt(1, 32'h50, 3, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #1;
        tx_ready = 1'b1;
      end
    join
    wait_drain(100);
    chk("no_stall_on_backpressure", 64'(err_stall), 64'd0);

    // Watchdog: core sends 3 words then starves mid-packet
    do_reset();
    wd_gap_chk = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(ent(2, 1'b0, 32'h21 + 32'(i)));
    exp_q.push_back(ent(2, 1'b1, 32'hFFFF_FFFF));
    send_pkt(2, 32'h21, 3, 1'b0);
    wait_drain(200);
    wd_gap_chk = 1'b0;
    chk("err_stall_set", 64'(err_stall), 64'd1);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_stall_cleared", 64'(err_stall), 64'd0);

    // Reset mid-burst on channel 2; channel 0 must win first afterwards
    do_reset();
    mon_off = 1'b1;
    v[2] = 1'b1;
    d[2] = 32'hC0DE;
    l[2] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_grant", 64'(grant_ch), 64'd2);
    chk("pre_reset_tx_valid", 64'(tx_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("async_rst_tx_data", 64'(tx_data), 64'd0);
    chk("async_rst_tx_tag", 64'(tx_tag), 64'd0);
    chk("async_rst_req_ready", 64'(req_ready), 64'd0);
    chk("async_rst_grant_ch", 64'(grant_ch), 64'd0);
    v[2] = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    mon_off = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(ent(0, 1'b1, 32'hA1));
    exp_q.push_back(ent(1, 1'b1, 32'hB1));
    exp_q.push_back(ent(2, 1'b1, 32'hC1));
    fork
      send_pkt(0, 32'hA1, 1, 1'b1);
      send_pkt(1, 32'hB1, 1, 1'b1);
      send_pkt(2, 32'hC1, 1, 1'b1);
    join
    wait_drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
